// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared UART definitions: TX state encoding, data-length codes and the
// oversample default used by both the TX core and the RX front-end.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic [1:0] DBITS_5 = 2'b00;
  localparam logic [1:0] DBITS_6 = 2'b01;
  localparam logic [1:0] DBITS_7 = 2'b10;
  localparam logic [1:0] DBITS_8 = 2'b11;

  function automatic logic [3:0] data_bits_len(input logic [1:0] code);
    return 4'd5 + {2'b00, code};
  endfunction

  // Parity over the valid low-order data bits only; odd parity inverts the XOR.
  function automatic logic parity_calc(input logic [7:0] data,
                                       input logic [1:0] code,
                                       input logic       odd);
    logic [7:0] mask;
    mask = 8'hFF >> (2'd3 - code);
    return (^(data & mask)) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
`timescale 1ns/1ps
// Bit-period timer: counts baud ticks and flags the last tick of each bit.
// Held at zero while cleared so the first bit of a frame gets a full period.
module uart_tx_bit_timer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int CNT_W      = $clog2(OVERSAMPLE)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_baud_tick,
  output logic o_bit_end
);

  localparam logic [CNT_W-1:0] TC = CNT_W'(OVERSAMPLE - 1);

  logic [CNT_W-1:0] tick_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tick_cnt <= '0;
    end else if (i_clear) begin
      tick_cnt <= '0;
    end else if (i_baud_tick) begin
      tick_cnt <= (tick_cnt == TC) ? '0 : tick_cnt + 1'b1;
    end
  end

  assign o_bit_end = i_baud_tick & ~i_clear & (tick_cnt == TC);

endmodule

// File: rtl/uart_tx_core.sv
`timescale 1ns/1ps
// UART transmit engine: byte handshake in, LSB-first serial frame out,
// paced by the shared oversample baud tick.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int CNT_W      = $clog2(OVERSAMPLE)
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tx_en,
  input  logic       i_baud_tick,
  input  logic [1:0] i_data_bits,
  input  logic       i_parity_en,
  input  logic       i_parity_odd,
  input  logic       i_stop2,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic       o_tx_serial,
  output logic       o_tx_busy,
  output logic       o_tx_done
);

  tx_state_t  state;
  logic [7:0] shift_q;
  logic [2:0] bit_cnt;
  logic [2:0] last_bit_q;
  logic       par_en_q;
  logic       par_bit_q;
  logic       stop2_q;
  logic       stop_cnt;
  logic       run_q;
  logic       bit_end;
  logic       accept;
  logic       timer_clear;

  // run_q keeps ready low while reset is held without using reset as data.
  assign o_tx_ready  = run_q & i_tx_en & (state == IDLE) & ~o_tx_done;
  assign accept      = i_tx_valid & o_tx_ready;
  assign timer_clear = (state == IDLE) | ~i_tx_en;

  uart_tx_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE),
    .CNT_W      (CNT_W)
  ) u_bit_timer (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clear     (timer_clear),
    .i_baud_tick (i_baud_tick),
    .o_bit_end   (bit_end)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      shift_q     <= '0;
      bit_cnt     <= '0;
      last_bit_q  <= '0;
      par_en_q    <= 1'b0;
      par_bit_q   <= 1'b0;
      stop2_q     <= 1'b0;
      stop_cnt    <= 1'b0;
      run_q       <= 1'b0;
      o_tx_serial <= 1'b1;
      o_tx_busy   <= 1'b0;
      o_tx_done   <= 1'b0;
    end else begin
      run_q     <= 1'b1;
      o_tx_done <= 1'b0;
      if (!i_tx_en) begin
        state       <= IDLE;
        shift_q     <= '0;
        bit_cnt     <= '0;
        stop_cnt    <= 1'b0;
        o_tx_serial <= 1'b1;
        o_tx_busy   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              shift_q     <= i_tx_data;
              last_bit_q  <= 3'(data_bits_len(i_data_bits) - 4'd1);
              par_en_q    <= i_parity_en;
              par_bit_q   <= parity_calc(i_tx_data, i_data_bits, i_parity_odd);
              stop2_q     <= i_stop2;
              bit_cnt     <= '0;
              stop_cnt    <= 1'b0;
              state       <= START;
              o_tx_serial <= 1'b0;
              o_tx_busy   <= 1'b1;
            end
          end
          START: begin
            if (bit_end) begin
              o_tx_serial <= shift_q[0];
              shift_q     <= {1'b0, shift_q[7:1]};
              bit_cnt     <= '0;
              state       <= DATA;
            end
          end
          DATA: begin
            if (bit_end) begin
              if (bit_cnt == last_bit_q) begin
                if (par_en_q) begin
                  o_tx_serial <= par_bit_q;
                  state       <= PARITY;
                end else begin
                  o_tx_serial <= 1'b1;
                  stop_cnt    <= 1'b0;
                  state       <= STOP;
                end
              end else begin
                bit_cnt     <= bit_cnt + 3'd1;
                o_tx_serial <= shift_q[0];
                shift_q     <= {1'b0, shift_q[7:1]};
              end
            end
          end
          PARITY: begin
            if (bit_end) begin
              o_tx_serial <= 1'b1;
              stop_cnt    <= 1'b0;
              state       <= STOP;
            end
          end
          STOP: begin
            if (bit_end) begin
              if (stop2_q && !stop_cnt) begin
                stop_cnt <= 1'b1;
              end else begin
                stop_cnt    <= 1'b0;
                state       <= IDLE;
                o_tx_serial <= 1'b1;
                o_tx_busy   <= 1'b0;
                o_tx_done   <= 1'b1;
              end
            end
          end
          default: begin
            state       <= IDLE;
            o_tx_serial <= 1'b1;
            o_tx_busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
